video_wr_arbiter: RTL
=====================

VIDEO_WR_ARBITER -- requirements
Module: video_wr_arbiter

Interface
REQ-001 SHALL have parameter CH_NUM, default 5: number of write channels (2..8).
REQ-002 SHALL have parameter CTRL_ADDR_WIDTH, default 28: AXI address width.
REQ-003 SHALL have parameter MEM_DQ_WIDTH, default 32: one beat = MEM_DQ_WIDTH*8 bits, 8 address units.
REQ-004 SHALL have parameter BURST_LEN, default 16: beats per burst (1..16); axi_awlen = BURST_LEN-1.
REQ-005 SHALL have parameter FRAME_BURSTS, default 2100: bursts per channel frame region.
REQ-006 SHALL have parameter CH_ADDR_SHIFT, default 22: channel region base = ch << CH_ADDR_SHIFT.
REQ-007 SHALL have ports: clk  in  1  DDR user clock; all logic in this one domain.
REQ-008 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-009 SHALL have ports: ch_vsync  in  CH_NUM  per-channel frame sync, asynchronous to clk.
REQ-010 SHALL have ports: ch_rready  in  CH_NUM  channel buffer holds at least BURST_LEN beats.
REQ-011 SHALL have ports: ch_rd_en  out  CH_NUM  one-hot beat pop to the granted channel buffer.
REQ-012 SHALL have ports: ch_data  in  CH_NUM*MEM_DQ_WIDTH*8  packed beat data; channel k in slice k; show-ahead.
REQ-013 SHALL have ports: AXI AW (awaddr/awid/awlen/awsize/awburst out, awvalid out, awready in), W (wdata/wstrb/wvalid out, wready in), init_done out.

Function
REQ-014 SHALL run FSM IDLE -> ARB -> AW -> WR -> DONE -> IDLE.
REQ-015 IDLE: go to ARB when any ch_rready bit is set.
REQ-016 ARB: round-robin grant, search starting at (last_grant+1) mod CH_NUM; one cycle.
REQ-017 AW: awvalid=1 with stable awaddr, awid=grant index, awsize=3'b101, awburst=2'b01; leave on awvalid&awready.
REQ-018 WR: wvalid=1, wstrb all ones, wdata=ch_data[grant]; ch_rd_en[grant]=wvalid&wready; exactly BURST_LEN accepted beats, then DONE.
REQ-019 DONE: offset[grant] += BURST_LEN*8; one cycle; return to IDLE.
REQ-020 awaddr = base(grant) + offset[grant]; offset wraps to 0 after FRAME_BURSTS bursts.
REQ-021 Each ch_vsync SHALL pass a 2-flop synchroniser; rising edge sets pending_sof[k].
REQ-022 pending_sof[k] SHALL clear offset[k] to 0 in IDLE/ARB, or in DONE if k is granted (DONE increment suppressed); never mid-burst.
REQ-023 If several channels are ready simultaneously, each SHALL be granted within CH_NUM arbitration rounds (no starvation).
REQ-024 A channel whose ch_rready drops after grant SHALL still complete its burst; wvalid is not gated by ch_rready.
REQ-025 init_done SHALL rise once every channel has seen a vsync edge following at least one completed burst; sticky until reset.
REQ-026 AW and W SHALL never overlap; one outstanding burst maximum.

Reset
REQ-027 On rst low: FSM=IDLE, awvalid=0, wvalid=0, ch_rd_en=0, awaddr=0, offsets=0, pending_sof=0, last_grant=CH_NUM-1, init_done=0.
REQ-028 Reset mid-burst SHALL abort immediately with no further ch_rd_en pulses; the AXI slave is reset together.

Configuration
REQ-029 With VWA_PINGPONG_EN defined, each channel SHALL own two regions (bit CH_ADDR_SHIFT-1 selects); pending_sof toggles the write bank; output frame_bank[CH_NUM] presents the last completed bank.
REQ-030 Without VWA_PINGPONG_EN: single region per channel; frame_bank absent.

Verification
REQ-031 CH_NUM=5, only ch2 ready, awready/wready always 1 -> awaddr=0x800000, awid=2, 16 ch_rd_en[2] pulses, offset 128.
REQ-032 All 5 ready continuously -> grant order 0,1,2,3,4,0; each channel receives exactly 1 burst per 5.
REQ-033 wready toggles 1/0 -> still exactly 16 pops; wdata beats match ch_data in order; no pop when wready=0.
REQ-034 ch1 vsync edge during ch1 burst -> burst completes at old address; next ch1 awaddr = 0x400000.
REQ-035 FRAME_BURSTS=4, ch0 writes 5 bursts with no vsync -> 5th awaddr wraps to 0x0.
REQ-036 rst low at beat 7 -> wvalid/ch_rd_en 0 in the same cycle; after release first awaddr = base of ch0.

Source files
------------

// File: rtl/video_wr_arbiter.sv
// Round-robin burst write arbiter that merges CH_NUM video line buffers onto one AXI write port.
// Optional build macro VWA_PINGPONG_EN: two frame banks per channel plus a frame_bank output.
module video_wr_arbiter #(
  parameter int unsigned CH_NUM          = 5,
  parameter int unsigned CTRL_ADDR_WIDTH = 28,
  parameter int unsigned MEM_DQ_WIDTH    = 32,
  parameter int unsigned BURST_LEN       = 16,
  parameter int unsigned FRAME_BURSTS    = 2100,
  parameter int unsigned CH_ADDR_SHIFT   = 22
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CH_NUM-1:0]                 ch_vsync,
  input  logic [CH_NUM-1:0]                 ch_rready,
  output logic [CH_NUM-1:0]                 ch_rd_en,
  input  logic [CH_NUM*MEM_DQ_WIDTH*8-1:0]  ch_data,
  output logic [CTRL_ADDR_WIDTH-1:0]        axi_awaddr,
  output logic [$clog2(CH_NUM)-1:0]         axi_awid,
  output logic [7:0]                        axi_awlen,
  output logic [2:0]                        axi_awsize,
  output logic [1:0]                        axi_awburst,
  output logic                              axi_awvalid,
  input  logic                              axi_awready,
  output logic [MEM_DQ_WIDTH*8-1:0]         axi_wdata,
  output logic [MEM_DQ_WIDTH-1:0]           axi_wstrb,
  output logic                              axi_wvalid,
  input  logic                              axi_wready,
`ifdef VWA_PINGPONG_EN
  output logic [CH_NUM-1:0]                 frame_bank,
`endif
  output logic                              init_done
);

  localparam int unsigned GW         = $clog2(CH_NUM);
  localparam int unsigned BW         = MEM_DQ_WIDTH * 8;
  localparam int unsigned AW         = CTRL_ADDR_WIDTH;
  localparam int unsigned CW         = $clog2(BURST_LEN) + 1;
  localparam int unsigned BURST_STEP = BURST_LEN * 8;
  localparam int unsigned FRAME_SPAN = FRAME_BURSTS * BURST_STEP;
`ifdef VWA_PINGPONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_AW, S_WR, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d, last_q, last_d;
  logic [AW-1:0]     awaddr_q, awaddr_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic [CW-1:0]     beat_q, beat_d;
  logic [AW-1:0]     offset_q [CH_NUM];
  logic [AW-1:0]     offset_d [CH_NUM];
  logic [AW-1:0]     off_inc_c;
  logic [CH_NUM-1:0] pend_q, pend_d, clr_c;
  logic [CH_NUM-1:0] sync1_q, sync2_q, sync3_q, sof_rise_c;
  logic [CH_NUM-1:0] seen_q, seen_d, armed_q, armed_d;
  logic              init_q, init_d;
  logic [CH_NUM-1:0] bank_cur_c;
  logic              found_c;
  logic [GW-1:0]     pick_c;
  logic [BW-1:0]     data_a [CH_NUM];

  function automatic logic [AW-1:0] base_addr(input logic [GW-1:0] ch, input logic bank);
    base_addr = (AW'(ch) << CH_ADDR_SHIFT) | (bank ? (AW'(1) << (CH_ADDR_SHIFT - 1)) : AW'(0));
  endfunction

  for (genvar k = 0; k < CH_NUM; k++) begin : g_slice
    assign data_a[k] = ch_data[k*BW +: BW];
  end

  // Two-flop synchroniser plus an edge register per vsync line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= ch_vsync;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end
  assign sof_rise_c = sync2_q & ~sync3_q;

  // Round-robin search starting one past the last grant
  always_comb begin
    found_c = 1'b0;
    pick_c  = last_q;
    for (int unsigned i = 1; i <= CH_NUM; i++) begin
      logic [GW-1:0] idx;
      idx = GW'((32'(last_q) + i) % CH_NUM);
      if (!found_c && ch_rready[idx]) begin
        found_c = 1'b1;
        pick_c  = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    awaddr_d  = awaddr_q;
    awvalid_d = 1'b0;
    wvalid_d  = 1'b0;
    beat_d    = beat_q;
    offset_d  = offset_q;
    seen_d    = seen_q;
    clr_c     = '0;
    off_inc_c = offset_q[grant_q] + AW'(BURST_STEP);
    case (state_q)
      S_IDLE: begin
        clr_c = pend_q;
        if (|ch_rready) state_d = S_ARB;
      end
      S_ARB: begin
        clr_c = pend_q;
        if (found_c) begin
          grant_d   = pick_c;
          last_d    = pick_c;
          beat_d    = '0;
          awvalid_d = 1'b1;
          state_d   = S_AW;
          // A start-of-frame cleared in this same cycle must already show in the address
          awaddr_d  = base_addr(pick_c, bank_cur_c[pick_c] ^ (PP & pend_q[pick_c]))
                    + (pend_q[pick_c] ? AW'(0) : offset_q[pick_c]);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_AW: begin
        awvalid_d = 1'b1;
        if (axi_awready) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          state_d   = S_WR;
        end
      end
      S_WR: begin
        wvalid_d = 1'b1;
        if (axi_wready) begin
          if (beat_q == CW'(BURST_LEN - 1)) begin
            wvalid_d = 1'b0;
            state_d  = S_DONE;
          end else begin
            beat_d = beat_q + CW'(1);
          end
        end
      end
      S_DONE: begin
        seen_d[grant_q] = 1'b1;
        if (pend_q[grant_q]) begin
          clr_c[grant_q] = 1'b1;
        end else begin
          offset_d[grant_q] = (off_inc_c >= AW'(FRAME_SPAN)) ? AW'(0) : off_inc_c;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      if (clr_c[k]) offset_d[k] = '0;
    end
    pend_d  = (pend_q & ~clr_c) | sof_rise_c;
    armed_d = armed_q | (sof_rise_c & seen_q);
    init_d  = init_q | (&armed_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      last_q    <= GW'(CH_NUM - 1);
      awaddr_q  <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      beat_q    <= '0;
      pend_q    <= '0;
      seen_q    <= '0;
      armed_q   <= '0;
      init_q    <= 1'b0;
      for (int unsigned k = 0; k < CH_NUM; k++) offset_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      awaddr_q  <= awaddr_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      beat_q    <= beat_d;
      pend_q    <= pend_d;
      seen_q    <= seen_d;
      armed_q   <= armed_d;
      init_q    <= init_d;
      offset_q  <= offset_d;
    end
  end

`ifdef VWA_PINGPONG_EN
  logic [CH_NUM-1:0] bank_q, fbank_q;

  // Each consumed start-of-frame flips the write bank; the bank just left is the finished frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_q  <= '0;
      fbank_q <= '0;
    end else begin
      bank_q  <= bank_q ^ clr_c;
      fbank_q <= (fbank_q & ~clr_c) | (bank_q & clr_c);
    end
  end
  assign bank_cur_c = bank_q;
  assign frame_bank = fbank_q;
`else
  assign bank_cur_c = '0;
`endif

  assign axi_awaddr  = awaddr_q;
  assign axi_awid    = grant_q;
  assign axi_awlen   = 8'(BURST_LEN - 1);
  assign axi_awsize  = 3'b101;
  assign axi_awburst = 2'b01;
  assign axi_awvalid = awvalid_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_wstrb   = '1;
  assign axi_wdata   = data_a[grant_q];
  assign ch_rd_en    = (wvalid_q & axi_wready) ? (CH_NUM'(1) << grant_q) : '0;
  assign init_done   = init_q;

endmodule
